// File: rtl/vga_dither_ordered_pkg.sv
// Shared definitions for the ordered-dither stage.
// Holds the 4x4 Bayer threshold table, the mode encodings and the helper
// that rescales a 4-bit threshold to the width of the discarded pixel bits.
package vga_dither_pkg;

    localparam int unsigned TS_W = 8;

    typedef enum logic [1:0] {
        MODE_TRUNC = 2'b00,
        MODE_B2    = 2'b01,
        MODE_B4    = 2'b10,
        MODE_B4T   = 2'b11
    } mode_e;

    localparam logic [3:0] BAYER4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    // Bayer table lookup by row/column.
    function automatic logic [3:0] bayer_lookup(input logic [1:0] row, input logic [1:0] col);
        return BAYER4[row][col];
    endfunction

    // Align a 4-bit threshold to a DIFF-bit remainder (DIFF in 1..8).
    function automatic logic [TS_W-1:0] scale_ts(input logic [3:0] t, input int unsigned diff);
        logic [TS_W-1:0] t_ext;
        t_ext = TS_W'(t);
        if (diff <= 4) begin
            return t_ext >> (4 - diff);
        end
        return t_ext << (diff - 4);
    endfunction

endpackage

// File: rtl/vga_dither_ordered_if.sv
// Video bus between pixel source, dither stage and DAC pins.
// I_* : mode request, syncs, data-enable and pixel into the stage.
// O_* : syncs, data-enable and dithered pixel out of the stage.
// master = source/sink side, slave = the dither stage.
interface vga_dither_ordered_if #(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned IN_W     = 8,
    parameter int unsigned OUT_W    = 4
);
    logic [1:0]                I_mode;
    logic                      I_hsync;
    logic                      I_vsync;
    logic                      I_de;
    logic [CHANNELS*IN_W-1:0]  I_rgb;
    logic                      O_hsync;
    logic                      O_vsync;
    logic                      O_de;
    logic [CHANNELS*OUT_W-1:0] O_rgb;

    modport master (
        output I_mode, I_hsync, I_vsync, I_de, I_rgb,
        input  O_hsync, O_vsync, O_de, O_rgb
    );

    modport slave (
        input  I_mode, I_hsync, I_vsync, I_de, I_rgb,
        output O_hsync, O_vsync, O_de, O_rgb
    );
endinterface

// File: rtl/vga_dither_ordered_channel.sv
// One colour channel of the ordered dither (combinational).
// in_data    : IN_W-bit input sample
// ts         : threshold already scaled to the remainder width
// dith_en    : 0 = plain truncation
// out_data_c : OUT_W-bit result, rounded up when remainder > ts, saturating
module vga_dither_ordered_channel
    import vga_dither_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 4
) (
    input  logic [IN_W-1:0]  in_data,
    input  logic [TS_W-1:0]  ts,
    input  logic             dith_en,
    output logic [OUT_W-1:0] out_data_c
);
    localparam int unsigned DIFF = IN_W - OUT_W;

    logic [OUT_W-1:0] q_c;
    logic [DIFF-1:0]  r_c;
    logic             inc_c;

    // Split into kept/discarded bits and round up against the threshold.
    always_comb begin
        q_c        = in_data[IN_W-1:DIFF];
        r_c        = in_data[DIFF-1:0];
        inc_c      = dith_en && (TS_W'(r_c) > ts);
        out_data_c = q_c;
        if (inc_c && (q_c != {OUT_W{1'b1}})) begin
            out_data_c = q_c + OUT_W'(1);
        end
    end
endmodule

// File: rtl/vga_dither_ordered.sv
// Ordered-dither stage between pixel generator and VGA DAC.
// I_clk     : pixel clock
// I_reset_n : synchronous active-low reset
// bus       : video in/out (mode, syncs, de, pixel), fixed 1-cycle latency
// Tracks a 4x4 screen position from syncs/de, latches the mode and a frame
// counter on each vsync rising edge, and dithers every channel with the
// threshold of the current (pre-update) position.
module vga_dither_ordered
    import vga_dither_pkg::*;
#(
    parameter int unsigned CHANNELS = 3,
    parameter int unsigned IN_W     = 8,
    parameter int unsigned OUT_W    = 4
) (
    input logic                  I_clk,
    input logic                  I_reset_n,
    vga_dither_ordered_if.slave  bus
);
    localparam int unsigned DIFF      = IN_W - OUT_W;
    localparam int unsigned RGB_OUT_W = CHANNELS * OUT_W;

    // Unsigned wrap makes OUT_W > IN_W land in the illegal range as well.
    if ((DIFF == 0) || (DIFF > 8)) begin : g_bad_diff
        $error("vga_dither_ordered: IN_W-OUT_W must be in 1..8");
    end

    logic [1:0]           col_q, col_d;
    logic [1:0]           row_q, row_d;
    logic [1:0]           frame_q, frame_d;
    mode_e                mode_q, mode_d;
    logic                 prev_hsync_q, prev_hsync_d;
    logic                 prev_vsync_q, prev_vsync_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 de_q, de_d;
    logic [RGB_OUT_W-1:0] rgb_q, rgb_d;

    logic                 hs_rise_c;
    logic                 vs_rise_c;
    logic                 dith_en_c;
    logic [3:0]           thr_c;
    logic [TS_W-1:0]      ts_c;
    logic [RGB_OUT_W-1:0] dith_rgb_c;

    assign hs_rise_c = bus.I_hsync & ~prev_hsync_q;
    assign vs_rise_c = bus.I_vsync & ~prev_vsync_q;

    // Threshold for the current position under the latched mode.
    always_comb begin
        thr_c = '0;
        case (mode_q)
            MODE_B2:  thr_c = bayer_lookup({1'b0, row_q[0]}, {1'b0, col_q[0]});
            MODE_B4:  thr_c = bayer_lookup(row_q, col_q);
            MODE_B4T: thr_c = bayer_lookup(row_q, col_q) + {frame_q, 2'b00};
            default:  thr_c = '0;
        endcase
        ts_c      = scale_ts(thr_c, DIFF);
        dith_en_c = (mode_q != MODE_TRUNC);
    end

    // Channel 0 occupies the most significant slot.
    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        localparam int unsigned SLOT = CHANNELS - 1 - ch;
        vga_dither_ordered_channel #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W)
        ) u_chan (
            .in_data    (bus.I_rgb[SLOT*IN_W +: IN_W]),
            .ts         (ts_c),
            .dith_en    (dith_en_c),
            .out_data_c (dith_rgb_c[SLOT*OUT_W +: OUT_W])
        );
    end

    // Position/frame/mode update; vsync edge wins over hsync edge over de.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        frame_d      = frame_q;
        mode_d       = mode_q;
        prev_hsync_d = bus.I_hsync;
        prev_vsync_d = bus.I_vsync;
        hsync_d      = bus.I_hsync;
        vsync_d      = bus.I_vsync;
        de_d         = bus.I_de;
        rgb_d        = bus.I_de ? dith_rgb_c : '0;

        if (vs_rise_c) begin
            row_d   = '0;
            col_d   = '0;
            frame_d = frame_q + 2'd1;
            mode_d  = mode_e'(bus.I_mode);
        end else if (hs_rise_c) begin
            row_d = row_q + 2'd1;
            col_d = '0;
        end else if (bus.I_de) begin
            col_d = col_q + 2'd1;
        end
    end

    // State and output registers.
    always_ff @(posedge I_clk) begin
        if (!I_reset_n) begin
            col_q        <= '0;
            row_q        <= '0;
            frame_q      <= '0;
            mode_q       <= MODE_TRUNC;
            prev_hsync_q <= 1'b0;
            prev_vsync_q <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            de_q         <= 1'b0;
            rgb_q        <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            frame_q      <= frame_d;
            mode_q       <= mode_d;
            prev_hsync_q <= prev_hsync_d;
            prev_vsync_q <= prev_vsync_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            de_q         <= de_d;
            rgb_q        <= rgb_d;
        end
    end

    assign bus.O_hsync = hsync_q;
    assign bus.O_vsync = vsync_q;
    assign bus.O_de    = de_q;
    assign bus.O_rgb   = rgb_q;

endmodule

// File: doc/vga_dither_ordered.md
# vga_dither_ordered

Parametrised ordered-dither stage that reduces CHANNELS colour channels from IN_W to OUT_W bits each. It supports a run-time selectable mode: truncate, 2x2 Bayer, 4x4 Bayer, or 4x4 Bayer with 4-frame temporal rotation. The block sits between the pixel generator and the VGA DAC pins. It tracks pixel position from the data-enable and sync inputs, and registers syncs, data-enable and pixels with fixed 1-cycle latency.

## Interface
- CHANNELS, 3, number of colour channels, packed MSB-first (channel 0 = R in bits [CHANNELS*IN_W-1 -: IN_W])
- IN_W, 8, input bits per channel
- OUT_W, 4, output bits per channel; DIFF = IN_W-OUT_W, legal range 1..8 (elaboration error otherwise)
- I_clk  in  1  pixel clock, all logic on rising edge
- I_reset_n  in  1  synchronous, active-low reset
- I_mode  in  2  requested mode: 00 truncate, 01 Bayer 2x2, 10 Bayer 4x4, 11 Bayer 4x4 temporal
- I_hsync  in  1  horizontal sync; rising edge = new line
- I_vsync  in  1  vertical sync; rising edge = new frame
- I_de  in  1  data enable, high for visible pixels
- I_rgb  in  CHANNELS*IN_W  input pixel
- O_hsync  out  1  I_hsync delayed 1 cycle
- O_vsync  out  1  I_vsync delayed 1 cycle
- O_de  out  1  I_de delayed 1 cycle
- O_rgb  out  CHANNELS*OUT_W  dithered pixel; 0 when O_de low

## Operation
- **State:**
  - col[1:0] and row[1:0]: position counters.
  - frame[1:0]: frame counter.
  - mode_q[1:0]: active mode.
  - prev_hsync, prev_vsync: edge detectors.
- **Counter update priority, per cycle:**
  - vsync rising edge (prev_vsync=0, I_vsync=1): row←0, col←0, frame←frame+1 (wraps 3→0), mode_q←I_mode. This overrides the two rules below; a simultaneous hsync rising edge is ignored for row.
  - else hsync rising edge: row←row+1 (mod 4), col←0.
  - else I_de=1: col←col+1 (mod 4).
- **Mode latching:** changes to I_mode take effect only at the next vsync rising edge, so no mid-frame pattern switch.
- **Bayer matrix B[row][col] (4-bit values):**
  - row 0: 0 8 2 10
  - row 1: 12 4 14 6
  - row 2: 3 11 1 9
  - row 3: 15 7 13 5
- **Threshold T per mode_q** (uses the current, pre-update col/row):
  - 00: no dithering.
  - 01: T = B[row[0]][col[0]].
  - 10: T = B[row][col].
  - 11: T = (B[row][col] + 4*frame) mod 16.
- **Scaled threshold ts:**
  - DIFF≤4: ts = T >> (4-DIFF).
  - DIFF>4: ts = T << (DIFF-4).
- **Per channel:**
  - q = in[IN_W-1:DIFF] and r = in[DIFF-1:0].
  - inc = (mode_q≠00) && (r > ts).
  - out = inc ? min(q+1, 2^OUT_W-1) : q. This saturates and never wraps.
- **Blanking:** when I_de=0, O_rgb is registered as 0 regardless of I_rgb.

## Timing
- Latency is exactly 1 cycle for all outputs, with syncs, de and pixel kept mutually aligned. There is no stall or backpressure.
- **During reset** (I_reset_n=0 at a clock edge):
  - Outputs: O_hsync, O_vsync, O_de and O_rgb = 0.
  - Internal state: col, row, frame, mode_q = 0 and prev_hsync, prev_vsync = 0.
- **Reset mid-frame:** the mode is truncate until the first vsync rising edge after reset release. If I_vsync is already high at release, this counts as a rising edge on the first cycle.
- The pixel at the cycle of an hsync or vsync edge uses the pre-update counters. Visible pixels normally start with col=0.

## Structure
- Package/include vga_dither_pkg holds:
  - the Bayer 4x4 constant table;
  - mode encodings MODE_TRUNC, MODE_B2, MODE_B4, MODE_B4T;
  - the threshold-scaling function.
- Sub-module vga_dither_ordered_channel (combinational; ports: in data, ts, dither enable, out data). It is instantiated CHANNELS times in a generate loop.
- Counters, edge detection, mode latch and output registers live in the top module.

## Test plan
- **Reset:** I_reset_n=0 for 5 cycles with I_de=1, I_rgb=0xFFFFFF → all outputs 0. After release, before any vsync edge, I_rgb=0x8F8F8F → O_rgb=0x888.
- **Mode 10:** all pixels 0x88 over 4 lines × 4 pixels → line 0 = 9,8,9,8; line 1 = 8,9,8,9; line 2 = 9,8,9,8; line 3 = 8,9,8,9 (8 of 16 positions are 9).
- **Saturation:** mode 10, all pixels 0xFF → O_rgb=0xFFF at every position, never 0x000.
- **Mode 11:** pixel (0,0)=0x84 over frames 0..3 → T=4,8,12,0 (frame increments on the latching vsync) → 8,8,8,9 repeating. With I_de=0, O_rgb=0.
- **Mode change mid-frame:** switch 10→00 after line 1 → pattern unchanged until the next vsync rising edge, then truncated output. Simultaneous hsync+vsync rising edges → row=0, col=0.
- **Generic config:** CHANNELS=1, IN_W=10, OUT_W=8 (DIFF=2), mode 10, input 0x202 (q=0x80, r=2) → 0x81 where B<8 (ts<2), else 0x80.
